seg_scan_decoder: RTL and testbench
===================================

Name: seg_scan_decoder

Overview:
- Receiving end of the 4-digit multiplexed 7-segment display interface. It samples the scanned digit-select and segment lines, rebuilds the 4-character frame, and decodes it back into a message code: ERR, OFF, ON, OPEN, SOUND or UNKNOWN.
- Used on the board-test fixture and in self-check loops to confirm what the display driver is actually showing.
- Includes stability filtering, frame assembly, multi-frame debounce and loss-of-scan detection.

Parameters:
- SETTLE_CYCLES, 8: number of cycles digit_sel must stay unchanged before segment is sampled.
- MATCH_FRAMES, 3: number of consecutive identical decoded frames needed before state_code changes.
- TIMEOUT_CYCLES, 262144: cycles with no completed frame before display_lost is asserted.
- SEG_ACTIVE_LOW, 1: when 1, segment lines are inverted before decode (common-anode).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- digit_sel  in  4  one-hot digit enable; bit3 is the leftmost digit (d3), bit0 is d0.
- segment  in  8  segment lines; [6:0]=g..a, [7]=dp (dp is ignored).
- state_code  out  3  000 ERR, 001 OFF, 010 ON, 011 OPEN, 100 SOUND, 111 UNKNOWN.
- state_valid  out  1  one-cycle pulse whenever state_code changes.
- display_lost  out  1  high while the scan has timed out.
- sel_glitch  out  1  one-cycle pulse when a non-one-hot, non-zero digit_sel is seen after settling.

Behaviour:
- Input synchronisation:
  - digit_sel and segment each pass through a 2-flop synchroniser.
  - All logic below uses the synchronised copies.
  - Input-to-first-effect latency is 2 cycles.
- Reset values: state_code=111, state_valid=0, display_lost=0, sel_glitch=0, all slots empty, all counters 0, FSM in WAIT_SEL.
- Reset mid-frame discards every partial slot and the match count. No output pulse is generated on leaving reset.
- Scan FSM:
  - WAIT_SEL: when digit_sel is non-zero, load it into cur_sel, clear settle_cnt, go to SETTLE.
  - SETTLE: if digit_sel differs from cur_sel, restart SETTLE with the new value (or return to WAIT_SEL if it is zero). Otherwise increment settle_cnt; when it reaches SETTLE_CYCLES-1, go to SAMPLE.
  - SAMPLE (one cycle):
    - If cur_sel is one-hot: store segment[6:0] (inverted when SEG_ACTIVE_LOW=1) in slot[index], set filled[index], go to HOLD.
    - Otherwise: pulse sel_glitch, store nothing, go to HOLD.
  - HOLD: stay until digit_sel changes, then take the WAIT_SEL action on the new value in that same cycle.
- Frame completion:
  - A frame completes in the cycle after filled becomes 4'b1111. That cycle clears filled.
  - Re-sampling a digit that is already filled overwrites its slot and is not an error.
- Character patterns (active-high, gfedcba): E=79, r=50, blank=00, O=3F, F=71, n=54, P=73, S=6D, d=5E (hex).
- Message table, listed d3..d0:
  - ERR = E r r blank
  - OFF = blank O F F
  - ON = blank blank O n
  - OPEN = O P E n
  - SOUND = blank S n d
  - Any other frame decodes to UNKNOWN (111).
- Debounce:
  - If a frame decodes to the same code as the previous frame, match_cnt increments, saturating at MATCH_FRAMES. Otherwise match_cnt is set to 1.
  - When match_cnt reaches MATCH_FRAMES and the code differs from state_code: update state_code and pulse state_valid in the next cycle.
  - A steady display therefore produces exactly one state_valid pulse.
- Timeout:
  - to_cnt increments every cycle and clears on each frame completion.
  - At TIMEOUT_CYCLES-1: set display_lost, set state_code=111, pulse state_valid if state_code was not already 111, clear match_cnt.
  - display_lost clears on the next frame completion.
  - If timeout and frame completion fall in the same cycle, frame completion wins.

Optional Feature:
- Macro SEG_FRAME_COUNT_EN.
- When defined: adds output frame_count [15:0]. It increments on every completed frame, saturates at FFFF, and is cleared by rst.
- When undefined: the port and its counter do not exist. All other behaviour is identical.

Decomposition:
- Package seg_scan_pkg holds:
  - the 3-bit message code constants;
  - the 7-bit character pattern constants;
  - the four-character message table as constants.
- One sub-module, seg_frame_match: purely combinational. Takes the 4×7-bit slots and returns a 3-bit code.
- Synchroniser, scan FSM, debounce and timeout live in the top-level module.

Test Plan:
- Scan "OPEn" (active-low patterns, each digit held 50 cycles, cycling d3..d0) for 3 frames -> single state_valid pulse and state_code=011 one cycle after the 3rd frame completes; no further pulses while the scan continues.
- Alternate ERR and OFF frame by frame for 10 frames -> state_code stays 111 and state_valid never pulses.
- digit_sel = 0011 held 40 cycles inside a valid ON scan -> exactly one sel_glitch pulse; the frame still completes on later valid digits; state_code=010 after 3 good frames.
- Each digit held only 5 cycles (shorter than SETTLE_CYCLES=8) -> no slot is captured and state_code stays at its reset value; after TIMEOUT_CYCLES, display_lost=1.
- Steady SOUND reached (state_code=100), then scan stops -> at TIMEOUT_CYCLES display_lost=1, state_code=111, one state_valid pulse; scan resumes -> display_lost clears on the first frame, state_code=100 after 3 frames.
- rst asserted with d3..d1 filled -> all slots cleared; a following single d0 sample does not complete a frame.

Source files
------------

// File: rtl/seg_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_pkg
// Description : Shared constants for the 7-segment scan decoder. It holds the
//               message codes, the active-high character patterns (gfedcba),
//               the four-character message table (d3..d0) and helper
//               functions.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_scan_pkg;

  // Message codes reported on state_code
  localparam logic [2:0] c_code_err     = 3'b000;
  localparam logic [2:0] c_code_off     = 3'b001;
  localparam logic [2:0] c_code_on      = 3'b010;
  localparam logic [2:0] c_code_open    = 3'b011;
  localparam logic [2:0] c_code_sound   = 3'b100;
  localparam logic [2:0] c_code_unknown = 3'b111;

  // Character patterns, active-high, bit order g..a
  localparam logic [6:0] c_chr_e     = 7'h79;
  localparam logic [6:0] c_chr_r     = 7'h50;
  localparam logic [6:0] c_chr_blank = 7'h00;
  localparam logic [6:0] c_chr_o     = 7'h3F;
  localparam logic [6:0] c_chr_f     = 7'h71;
  localparam logic [6:0] c_chr_n     = 7'h54;
  localparam logic [6:0] c_chr_p     = 7'h73;
  localparam logic [6:0] c_chr_s     = 7'h6D;
  localparam logic [6:0] c_chr_d     = 7'h5E;

  // Message table: {d3, d2, d1, d0}
  localparam logic [27:0] c_msg_err   = {c_chr_e,     c_chr_r,     c_chr_r, c_chr_blank};
  localparam logic [27:0] c_msg_off   = {c_chr_blank, c_chr_o,     c_chr_f, c_chr_f};
  localparam logic [27:0] c_msg_on    = {c_chr_blank, c_chr_blank, c_chr_o, c_chr_n};
  localparam logic [27:0] c_msg_open  = {c_chr_o,     c_chr_p,     c_chr_e, c_chr_n};
  localparam logic [27:0] c_msg_sound = {c_chr_blank, c_chr_s,     c_chr_n, c_chr_d};

  // Scan FSM states
  typedef enum logic [1:0] {
    S_WAIT_SEL = 2'd0,
    S_SETTLE   = 2'd1,
    S_SAMPLE   = 2'd2,
    S_HOLD     = 2'd3
  } scan_state_t;

  // True when exactly one digit enable is active
  function automatic logic is_onehot(input logic [3:0] sel);
    return (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
  endfunction

  // Slot index of a one-hot digit enable (bit3 = d3)
  function automatic logic [1:0] sel_to_index(input logic [3:0] sel);
    logic [1:0] idx;
    idx = 2'd0;
    if (sel[1]) idx = 2'd1;
    if (sel[2]) idx = 2'd2;
    if (sel[3]) idx = 2'd3;
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_frame_match.sv
`default_nettype none
// ============================================================================
// Module      : seg_frame_match
// Description : Combinational lookup of a rebuilt 4-character frame against
//               the message table; anything unrecognised maps to UNKNOWN.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_frame_match
  import seg_scan_pkg::*;
(
  input  logic [27:0] i_frame,   // {d3, d2, d1, d0}, active-high patterns
  output logic [2:0]  o_code
);

  // Compare the frame with each table entry, default to UNKNOWN
  always_comb begin
    o_code = c_code_unknown;
    if      (i_frame == c_msg_err)   o_code = c_code_err;
    else if (i_frame == c_msg_off)   o_code = c_code_off;
    else if (i_frame == c_msg_on)    o_code = c_code_on;
    else if (i_frame == c_msg_open)  o_code = c_code_open;
    else if (i_frame == c_msg_sound) o_code = c_code_sound;
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_decoder
// Description : Receiver for a 4-digit multiplexed 7-segment display. It
//               synchronises the scan lines, samples each settled digit,
//               assembles frames, debounces the decoded message over several
//               frames and flags loss of scan.
//               Optional: define SEG_FRAME_COUNT_EN to add o_frame_count.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 8,
  parameter int MATCH_FRAMES   = 3,
  parameter int TIMEOUT_CYCLES = 262144,
  parameter int SEG_ACTIVE_LOW = 1
)(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  i_digit_sel,
  input  logic [7:0]  i_segment,
  output logic [2:0]  o_state_code,
  output logic        o_state_valid,
  output logic        o_display_lost,
`ifdef SEG_FRAME_COUNT_EN
  output logic [15:0] o_frame_count,
`endif
  output logic        o_sel_glitch
);

  localparam int c_settle_w = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int c_match_w  = $clog2(MATCH_FRAMES + 1);
  localparam int c_to_w     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [c_settle_w-1:0] c_settle_last = c_settle_w'(SETTLE_CYCLES - 1);
  localparam logic [c_match_w-1:0]  c_match_max   = c_match_w'(MATCH_FRAMES);
  localparam logic [c_to_w-1:0]     c_to_last     = c_to_w'(TIMEOUT_CYCLES - 1);

  // Synchronisers; the decimal point is never decoded
  logic [3:0] r_sel_s1, r_sel_s2;
  logic [6:0] r_seg_s1, r_seg_s2;
  logic       w_unused_dp;
  logic [3:0] w_sel;
  logic [6:0] w_seg_pat;

  assign w_unused_dp = i_segment[7];
  assign w_sel       = r_sel_s2;
  assign w_seg_pat   = (SEG_ACTIVE_LOW != 0) ? ~r_seg_s2 : r_seg_s2;

  // Two-flop synchronisers on the scan lines
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel_s1 <= 4'd0;
      r_sel_s2 <= 4'd0;
      r_seg_s1 <= 7'd0;
      r_seg_s2 <= 7'd0;
    end else begin
      r_sel_s1 <= i_digit_sel;
      r_sel_s2 <= r_sel_s1;
      r_seg_s1 <= i_segment[6:0];
      r_seg_s2 <= r_seg_s1;
    end
  end

  // Scan FSM
  scan_state_t            r_state, w_state_nxt;
  logic [3:0]             r_cur_sel, w_cur_sel_nxt;
  logic [c_settle_w-1:0]  r_settle_cnt, w_settle_nxt;
  logic                   w_capture, w_glitch;

  // State register for the scan FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_WAIT_SEL;
      r_cur_sel    <= 4'd0;
      r_settle_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cur_sel    <= w_cur_sel_nxt;
      r_settle_cnt <= w_settle_nxt;
    end
  end

  // Next-state logic: wait for a select, let it settle, sample once, hold
  always_comb begin
    w_state_nxt   = r_state;
    w_cur_sel_nxt = r_cur_sel;
    w_settle_nxt  = r_settle_cnt;
    w_capture     = 1'b0;
    w_glitch      = 1'b0;
    case (r_state)
      S_WAIT_SEL: begin
        if (w_sel != 4'd0) begin
          w_cur_sel_nxt = w_sel;
          w_settle_nxt  = '0;
          w_state_nxt   = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (w_sel != r_cur_sel) begin
          if (w_sel == 4'd0) begin
            w_state_nxt = S_WAIT_SEL;
          end else begin
            w_cur_sel_nxt = w_sel;
            w_settle_nxt  = '0;
          end
        end else begin
          w_settle_nxt = r_settle_cnt + 1'b1;
          if ((r_settle_cnt + 1'b1) == c_settle_last) begin
            w_state_nxt = S_SAMPLE;
          end
        end
      end
      S_SAMPLE: begin
        if (is_onehot(r_cur_sel)) w_capture = 1'b1;
        else                      w_glitch  = 1'b1;
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        // A new select is treated exactly as WAIT_SEL would, in this cycle
        if (w_sel != r_cur_sel) begin
          if (w_sel == 4'd0) begin
            w_state_nxt = S_WAIT_SEL;
          end else begin
            w_cur_sel_nxt = w_sel;
            w_settle_nxt  = '0;
            w_state_nxt   = S_SETTLE;
          end
        end
      end
      default: w_state_nxt = S_WAIT_SEL;
    endcase
  end

  // Frame assembly
  logic [3:0][6:0] r_slots;
  logic [3:0]      r_filled;
  logic            r_sel_glitch;
  logic            w_frame_done;
  logic [2:0]      w_code;

  assign w_frame_done = (r_filled == 4'b1111);

  // Slot capture; a completed frame empties the fill mask the cycle after
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slots      <= '0;
      r_filled     <= 4'd0;
      r_sel_glitch <= 1'b0;
    end else begin
      r_sel_glitch <= w_glitch;
      if (w_capture) begin
        r_slots[sel_to_index(r_cur_sel)] <= w_seg_pat;
      end
      if (w_frame_done) begin
        r_filled <= w_capture ? (4'd1 << sel_to_index(r_cur_sel)) : 4'd0;
      end else if (w_capture) begin
        r_filled[sel_to_index(r_cur_sel)] <= 1'b1;
      end
    end
  end

  seg_frame_match u_match (
    .i_frame (r_slots),
    .o_code  (w_code)
  );

  // Debounce: match_cnt of zero means there is no previous frame to compare
  logic [2:0]           r_prev_code;
  logic [c_match_w-1:0] r_match_cnt, w_match_nxt;
  logic [2:0]           r_state_code;
  logic                 r_state_valid;
  logic                 r_lost;
  logic [c_to_w-1:0]    r_to_cnt;
  logic                 w_same, w_commit;

  assign w_same      = (r_match_cnt != '0) && (w_code == r_prev_code);
  assign w_match_nxt = !w_same                    ? c_match_w'(1) :
                       (r_match_cnt == c_match_max) ? r_match_cnt  :
                                                      r_match_cnt + 1'b1;
  assign w_commit    = (w_match_nxt == c_match_max) && (w_code != r_state_code);

  // Debounce and timeout; a completing frame takes priority over the timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_code   <= c_code_unknown;
      r_match_cnt   <= '0;
      r_state_code  <= c_code_unknown;
      r_state_valid <= 1'b0;
      r_lost        <= 1'b0;
      r_to_cnt      <= '0;
    end else begin
      r_state_valid <= 1'b0;
      if (w_frame_done) begin
        r_to_cnt    <= '0;
        r_lost      <= 1'b0;
        r_prev_code <= w_code;
        r_match_cnt <= w_match_nxt;
        if (w_commit) begin
          r_state_code  <= w_code;
          r_state_valid <= 1'b1;
        end
      end else if (r_to_cnt == c_to_last) begin
        // Counter parks here until the scan returns
        r_lost        <= 1'b1;
        r_state_code  <= c_code_unknown;
        r_state_valid <= (r_state_code != c_code_unknown);
        r_match_cnt   <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

`ifdef SEG_FRAME_COUNT_EN
  logic [15:0] r_frame_count;

  // Saturating count of completed frames
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_count <= 16'd0;
    end else if (w_frame_done && (r_frame_count != 16'hFFFF)) begin
      r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign o_frame_count = r_frame_count;
`endif

  assign o_state_code   = r_state_code;
  assign o_state_valid  = r_state_valid;
  assign o_display_lost = r_lost;
  assign o_sel_glitch   = r_sel_glitch;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_decoder
// Description : Self-checking bench for seg_scan_decoder. Directed scans are
//               driven active-low; expected state_valid codes and sel_glitch
//               pulses are queued as stimulus is issued and consumed by a
//               monitor whenever the DUT pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_decoder;

  localparam int T_OUT = 2000;
  localparam int HOLD  = 50;

  // Hand-written message frames {d3,d2,d1,d0}, active-high gfedcba
  localparam logic [27:0] M_ERR   = {7'h79, 7'h50, 7'h50, 7'h00};
  localparam logic [27:0] M_OFF   = {7'h00, 7'h3F, 7'h71, 7'h71};
  localparam logic [27:0] M_ON    = {7'h00, 7'h00, 7'h3F, 7'h54};
  localparam logic [27:0] M_OPEN  = {7'h3F, 7'h73, 7'h79, 7'h54};
  localparam logic [27:0] M_SOUND = {7'h00, 7'h6D, 7'h54, 7'h5E};

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] i_digit_sel;
  logic [7:0] i_segment;
  logic [2:0] o_state_code;
  logic       o_state_valid;
  logic       o_display_lost;
  logic       o_sel_glitch;
`ifdef SEG_FRAME_COUNT_EN
  logic [15:0] o_frame_count;
`endif

  int checks   = 0;
  int failures = 0;
  logic [2:0] exp_q[$];
  int exp_glitch = 0;
  logic [2:0] mon_exp;

  always #5 clk = ~clk;

  seg_scan_decoder #(
    .SETTLE_CYCLES  (8),
    .MATCH_FRAMES   (3),
    .TIMEOUT_CYCLES (T_OUT),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_digit_sel    (i_digit_sel),
    .i_segment      (i_segment),
    .o_state_code   (o_state_code),
    .o_state_valid  (o_state_valid),
    .o_display_lost (o_display_lost),
`ifdef SEG_FRAME_COUNT_EN
    .o_frame_count  (o_frame_count),
`endif
    .o_sel_glitch   (o_sel_glitch)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every pulse must match the next queued expectation
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (o_state_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_state_valid actual_code=%0h required=no_pulse", o_state_code);
        end else begin
          mon_exp = exp_q.pop_front();
          if (o_state_code !== mon_exp) begin
            failures++;
            $display("FAIL state_valid_code actual=%0h required=%0h", o_state_code, mon_exp);
          end
        end
      end
      if (o_sel_glitch === 1'b1) begin
        checks++;
        if (exp_glitch == 0) begin
          failures++;
          $display("FAIL unexpected_sel_glitch actual=1 required=0");
        end else begin
          exp_glitch--;
        end
      end
    end
  end

  // All tasks start and end on a falling edge
  task automatic do_reset();
    i_digit_sel = 4'd0;
    i_segment   = 8'hFF;
    rst         = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive(input logic [3:0] sel, input logic [6:0] pat, input int hold);
    i_digit_sel = sel;
    i_segment   = {1'b1, ~pat};
    repeat (hold) @(negedge clk);
  endtask

  task automatic frame(input logic [27:0] msg, input int hold);
    drive(4'b1000, msg[27:21], hold);
    drive(4'b0100, msg[20:14], hold);
    drive(4'b0010, msg[13:7],  hold);
    drive(4'b0001, msg[6:0],   hold);
  endtask

  task automatic idle(input int n);
    i_digit_sel = 4'd0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int waited;
    rst         = 1'b1;
    i_digit_sel = 4'd0;
    i_segment   = 8'hFF;
    repeat (4) @(negedge clk);
    check("reset_state_code",   int'(o_state_code),   7);
    check("reset_state_valid",  int'(o_state_valid),  0);
    check("reset_display_lost", int'(o_display_lost), 0);
    check("reset_sel_glitch",   int'(o_sel_glitch),   0);
    rst = 1'b0;

    // Steady OPEN: one pulse after the third frame, silence afterwards
    exp_q.push_back(3'b011);
    repeat (3) frame(M_OPEN, HOLD);
    check("open_state_code", int'(o_state_code), 3);
    check("open_pulse_drained", exp_q.size(), 0);
    repeat (2) frame(M_OPEN, HOLD);
    check("open_state_code_steady", int'(o_state_code), 3);
`ifdef SEG_FRAME_COUNT_EN
    check("open_frame_count", int'(o_frame_count), 5);
`endif

    // Alternating ERR / OFF never settles
    do_reset();
    repeat (5) begin
      frame(M_ERR, HOLD);
      frame(M_OFF, HOLD);
    end
    check("alt_state_code", int'(o_state_code), 7);
    check("alt_display_lost", int'(o_display_lost), 0);

    // Non-one-hot select inside an ON scan
    do_reset();
    exp_glitch = 1;
    exp_q.push_back(3'b010);
    drive(4'b1000, M_ON[27:21], HOLD);
    drive(4'b0100, M_ON[20:14], HOLD);
    drive(4'b0011, M_ON[13:7],  40);
    drive(4'b0010, M_ON[13:7],  HOLD);
    drive(4'b0001, M_ON[6:0],   HOLD);
    repeat (2) frame(M_ON, HOLD);
    check("glitch_pulses_drained", exp_glitch, 0);
    check("on_pulse_drained", exp_q.size(), 0);
    check("on_state_code", int'(o_state_code), 2);

    // Digits too short to settle: no capture, then timeout
    do_reset();
    repeat (95) frame(M_OPEN, 5);
    check("short_lost_before_timeout", int'(o_display_lost), 0);
    check("short_state_code", int'(o_state_code), 7);
    repeat (15) frame(M_OPEN, 5);
    check("short_lost_after_timeout", int'(o_display_lost), 1);

    // SOUND, scan stops, then resumes
    do_reset();
    exp_q.push_back(3'b100);
    repeat (3) frame(M_SOUND, HOLD);
    check("sound_state_code", int'(o_state_code), 4);
    exp_q.push_back(3'b111);
    idle(T_OUT - 200);
    check("stop_lost_early", int'(o_display_lost), 0);
    waited = 0;
    while (o_display_lost !== 1'b1 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    check("stop_lost_asserted", int'(o_display_lost), 1);
    check("stop_state_code", int'(o_state_code), 7);
    @(negedge clk);
    check("stop_pulse_drained", exp_q.size(), 0);
    exp_q.push_back(3'b100);
    frame(M_SOUND, HOLD);
    check("resume_lost_cleared", int'(o_display_lost), 0);
    check("resume_code_pending", int'(o_state_code), 7);
    repeat (2) frame(M_SOUND, HOLD);
    check("resume_state_code", int'(o_state_code), 4);
    check("resume_pulse_drained", exp_q.size(), 0);

    // Reset with d3..d1 filled: a lone d0 afterwards completes nothing,
    // so the timeout runs from reset release undisturbed
    do_reset();
    drive(4'b1000, M_OPEN[27:21], HOLD);
    drive(4'b0100, M_OPEN[20:14], HOLD);
    drive(4'b0010, M_OPEN[13:7],  HOLD);
    do_reset();
    drive(4'b0001, M_OPEN[6:0], HOLD);
    idle(1990 - HOLD);
    check("rst_partial_lost_early", int'(o_display_lost), 0);
    idle(15);
    check("rst_partial_no_frame", int'(o_display_lost), 1);
    check("rst_partial_state_code", int'(o_state_code), 7);

    repeat (4) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_glitch_empty", exp_glitch, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
